// File: rtl/shared_adder_sequencer_if.sv
// Request/result bundle for the shared adder sequencer: two operand requesters
// on one side, a valid/ready result port on the other.
interface shared_adder_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       req;
    logic [1:0]       sub;
    logic [WIDTH-1:0] A0;
    logic [WIDTH-1:0] B0;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] B1;
    logic [1:0]       gnt;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] Z;
    logic             Cout;
    logic             res_id;

    modport master (
        output req, sub, A0, B0, A1, B1, res_ready,
        input  gnt, busy, res_valid, Z, Cout, res_id
    );

    modport slave (
        input  req, sub, A0, B0, A1, B1, res_ready,
        output gnt, busy, res_valid, Z, Cout, res_id
    );
endinterface

// File: rtl/shared_adder_sequencer.sv
// Two requesters share one 4-bit adder slice; each WIDTH-bit add/subtract is
// rippled LSB nibble first through a carry register, result on valid/ready.
module shared_adder_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    shared_adder_sequencer_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [4:0] nibble_add(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic       ci);
        nibble_add = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    endfunction

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             carry_q,     carry_d;
    logic             id_q,        id_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             prio_q,      prio_d;
    logic [WIDTH-1:0] z_q,         z_d;
    logic             cout_q,      cout_d;
    logic             res_id_q,    res_id_d;
    logic             res_valid_q, res_valid_d;

    logic             win_s;
    logic [1:0]       gnt_s;
    logic [4:0]       slice_s;
    logic [CW+1:0]    base_s;

    assign base_s  = {cnt_q, 2'b00};
    assign slice_s = nibble_add(a_q[base_s +: 4], b_q[base_s +: 4], carry_q);

    // Next-state, arbitration and nibble datapath
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        z_d         = z_q;
        cout_d      = cout_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        win_s       = 1'b0;
        gnt_s       = 2'b00;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    // prio_q names the requester that wins a tie
                    if (bus.req == 2'b11) begin
                        win_s = prio_q;
                    end else begin
                        win_s = bus.req[1];
                    end
                    if (!rst) begin
                        gnt_s = win_s ? 2'b10 : 2'b01;
                    end else begin
                        gnt_s = 2'b00;
                    end
                    a_d     = win_s ? bus.A1 : bus.A0;
                    b_d     = (win_s ? bus.B1 : bus.B0) ^ {WIDTH{bus.sub[win_s]}};
                    carry_d = bus.sub[win_s];
                    id_d    = win_s;
                    cnt_d   = {CW{1'b0}};
                    prio_d  = ~win_s;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[base_s +: 4] = slice_s[3:0];
                carry_d            = slice_s[4];
                cnt_d              = cnt_q + CW'(1);
                if (cnt_q == LAST_NIB) begin
                    z_d         = sum_d;
                    cout_d      = slice_s[4];
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    cnt_d       = {CW{1'b0}};
                    state_d     = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            id_q        <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            prio_q      <= 1'b0;
            z_q         <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            z_q         <= z_d;
            cout_q      <= cout_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.gnt       = gnt_s;
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.Z         = z_q;
    assign bus.Cout      = cout_q;
    assign bus.res_id    = res_id_q;
endmodule

// File: doc/shared_adder_sequencer.md
Name: shared_adder_sequencer

Overview:
- Time-shares one 4-bit full-adder slice (carry-in, carry-out) between two requesters.
- Each request is a WIDTH-bit add or subtract.
- A round-robin arbiter picks a requester. The block latches its operands, then ripples the operation through the slice one 4-bit nibble per cycle, LSB nibble first, carrying through a carry register.
- The result is presented on a valid/ready output port tagged with the requester id.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.
- NSLICE, WIDTH/4, number of nibble cycles per operation; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  2  req[i] high = requester i has an operation pending.
- sub  input  2  sub[i] = 1 selects A-B for requester i; 0 selects A+B.
- A0  input  WIDTH  requester 0 operand A.
- B0  input  WIDTH  requester 0 operand B.
- A1  input  WIDTH  requester 1 operand A.
- B1  input  WIDTH  requester 1 operand B.
- gnt  output  2  one-hot, one-cycle pulse: the granted requester's operands were captured this cycle.
- busy  output  1  high in RUN and DONE.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- Z  output  WIDTH  result.
- Cout  output  1  final carry; for subtract, 1 = no borrow.
- res_id  output  1  requester that produced Z.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, busy=0, res_valid=0, Z=0, Cout=0, res_id=0, nibble counter=0, carry reg=0, RR pointer favours requester 0. Any in-flight operation is discarded and no grant or result follows.
- FSM states: IDLE, RUN, DONE.
- IDLE, req==0: remain in IDLE, all outputs held.
- IDLE, req!=0: grant one requester.
  - Only one req set: that requester wins.
  - Both set: the requester not granted last wins (round-robin).
- On grant:
  - Capture Ai into the A register.
  - Capture Bi (or ~Bi when sub[i]) into the B register.
  - Carry reg = sub[i]; id reg = i; counter = 0.
  - Pulse gnt[i] for exactly that cycle. Update the RR pointer. Go to RUN.
- Operands are sampled only in the grant cycle. Later changes to Ai/Bi/sub do not affect the operation.
- RUN, each cycle with counter=k:
  - {c, s} = A[4k+3:4k] + B[4k+3:4k] + carry.
  - Write s to result nibble k; carry <= c; counter++.
  - After nibble NSLICE-1: load Z from the result reg, Cout = c, res_id = id; set res_valid=1; go to DONE.
- Latency: grant in cycle T; res_valid first high in cycle T+1+NSLICE (T+5 for WIDTH=16).
- Result arithmetic: Z = (A + B) mod 2^WIDTH, or (A - B) mod 2^WIDTH. Cout is carry out of the top bit.
- DONE: hold res_valid, Z, Cout and res_id stable until res_valid & res_ready.
  - That cycle: res_valid<=0 next edge; go to IDLE.
  - Z/Cout/res_id keep their last values after the handshake.
- A new grant is earliest in the cycle after the handshake. req is ignored while busy.
- Requesters must keep req high until they see gnt[i]. A requester that keeps req high after gnt issues a new operation; round-robin still alternates if the other requester is waiting.
- req dropping before grant: no operation, no gnt.
- res_ready high before res_valid has no effect.

Test Plan:
- Add, WIDTH=16: req=01, sub=00, A0=0x1234, B0=0x4321 -> gnt=01 at T; res_valid at T+5; Z=0x5555, Cout=0, res_id=0.
- Carry ripple through all nibbles: A1=0xFFFF, B1=0x0001, add -> Z=0x0000, Cout=1, res_id=1; intermediate carry reg=1 in every RUN cycle.
- Subtract: A0=0x0005, B0=0x0007, sub[0]=1 -> Z=0xFFFE, Cout=0.
- Subtract: A0=0x0007, B0=0x0005, sub[0]=1 -> Z=0x0002, Cout=1.
- Round-robin: req=11 held continuously, res_ready=1 -> grants alternate 01,10,01,10; each requester's operands appear with the correct res_id.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> Z/Cout/res_id stable, no gnt issued despite req=11. Raise res_ready -> handshake, IDLE, next gnt the following cycle.
- Mid-operation reset: assert rst in RUN cycle 2 -> immediately res_valid=0, busy=0, Z=0. After release with req=11 -> gnt=01 (pointer reset). No stale result ever appears.
- Operand change after grant: modify A0 in T+1 -> result still reflects the values captured at T.
